// File: rtl/fp_mul_seq.sv
// Sequential IEEE-754 single-precision multiplier (shift-add mantissa product, RNE rounding, FTZ).
// Latency: specials out_valid one edge after accept; normal operands 24/RADIX_BITS+2 edges after accept.
// Backpressure: in_ready only in IDLE; result/ovf/unf/out_valid held in DONE until out_ready.
module fp_mul_seq #(
  parameter int          RADIX_BITS = 1,
  parameter logic [31:0] CANON_NAN  = 32'h7FC00000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        a_zero,
  input  logic        a_inf,
  input  logic        a_nan,
  input  logic        b_zero,
  input  logic        b_inf,
  input  logic        b_nan,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result,
  output logic        ovf,
  output logic        unf
);

  localparam int         NCYC     = 24 / RADIX_BITS;
  localparam logic [4:0] CNT_LAST = 5'(NCYC - 1);

  typedef enum logic [1:0] {IDLE, MUL, RND, DONE} state_t;

  state_t      state, state_nxt;
  logic        sign;
  logic [7:0]  ea, eb;
  logic [23:0] ma, mb;
  logic [47:0] acc;
  logic [4:0]  cnt;

  logic        accept;
  logic        a_z, b_z, spec_hit;
  logic [31:0] spec_res;

  assign in_ready = (state == IDLE);
  assign accept   = in_valid & in_ready;

  // Subnormals flush to zero, so an exponent of 0 counts as zero for special handling.
  assign a_z      = a_zero | (a[30:23] == 8'h00);
  assign b_z      = b_zero | (b[30:23] == 8'h00);
  assign spec_hit = a_z | b_z | a_inf | a_nan | b_inf | b_nan;

  // Special-case result selection, highest priority first.
  always_comb begin
    spec_res = {a[31] ^ b[31], 31'h0};
    if (a_nan | b_nan)                        spec_res = CANON_NAN;
    else if ((a_inf & b_z) | (b_inf & a_z))   spec_res = CANON_NAN;
    else if (a_inf | b_inf)                   spec_res = {a[31] ^ b[31], 8'hFF, 23'h0};
  end

  // One radix step: add multiplicand x low digit into the upper half, then shift right.
  logic [23+RADIX_BITS:0] pp;
  logic [24+RADIX_BITS:0] sum;
  logic [48+RADIX_BITS:0] wide;
  always_comb begin
    pp   = {{RADIX_BITS{1'b0}}, ma} * {{24{1'b0}}, mb[RADIX_BITS-1:0]};
    sum  = {{(RADIX_BITS+1){1'b0}}, acc[47:24]} + {1'b0, pp};
    wide = {sum, acc[23:0]} >> RADIX_BITS;
  end

  // Normalise, round to nearest even, then detect overflow/underflow of the biased exponent.
  logic signed [9:0] e_base, e_norm, e_fin;
  logic [22:0] mant, mant_f;
  logic [23:0] mant_r;
  logic        g, s, rup, ovf_c, unf_c;
  logic [31:0] rnd_res;
  always_comb begin
    e_base = $signed({2'b00, ea}) + $signed({2'b00, eb}) - 10'sd127;
    if (acc[47]) begin
      mant   = acc[46:24];
      g      = acc[23];
      s      = |acc[22:0];
      e_norm = e_base + 10'sd1;
    end else begin
      mant   = acc[45:23];
      g      = acc[22];
      s      = |acc[21:0];
      e_norm = e_base;
    end
    rup    = g & (s | mant[0]);
    mant_r = {1'b0, mant} + {23'h0, rup};
    if (mant_r[23]) begin
      mant_f = 23'h0;
      e_fin  = e_norm + 10'sd1;
    end else begin
      mant_f = mant_r[22:0];
      e_fin  = e_norm;
    end
    ovf_c   = (e_fin >= 10'sd255);
    unf_c   = (e_fin <= 10'sd0);
    rnd_res = {sign, e_fin[7:0], mant_f};
    if (ovf_c)      rnd_res = {sign, 8'hFF, 23'h0};
    else if (unf_c) rnd_res = {sign, 31'h0};
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = spec_hit ? DONE : MUL;
      MUL:  if (cnt == CNT_LAST) state_nxt = RND;
      RND:  state_nxt = DONE;
      DONE: if (out_valid && out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Operand capture, iterative product, and registered result/flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sign   <= 1'b0;
      ea     <= 8'h0;
      eb     <= 8'h0;
      ma     <= 24'h0;
      mb     <= 24'h0;
      acc    <= 48'h0;
      cnt    <= 5'd0;
      result <= 32'h0;
      ovf    <= 1'b0;
      unf    <= 1'b0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          sign <= a[31] ^ b[31];
          ea   <= a[30:23];
          eb   <= b[30:23];
          ma   <= {1'b1, a[22:0]};
          mb   <= {1'b1, b[22:0]};
          acc  <= 48'h0;
          cnt  <= 5'd0;
          ovf  <= 1'b0;
          unf  <= 1'b0;
          if (spec_hit) result <= spec_res;
        end
        MUL: begin
          acc <= wide[47:0];
          mb  <= mb >> RADIX_BITS;
          cnt <= (cnt == CNT_LAST) ? 5'd0 : cnt + 5'd1;
        end
        RND: begin
          result <= rnd_res;
          ovf    <= ovf_c;
          unf    <= unf_c;
        end
        default: ;
      endcase
    end
  end

  // out_valid rises the edge after entering DONE and drops on the handshake edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) out_valid <= 1'b0;
    else if (state == DONE) begin
      if (!out_valid)     out_valid <= 1'b1;
      else if (out_ready) out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fp_mul_seq.sv
// Directed self-checking bench for fp_mul_seq at RADIX_BITS=1 and RADIX_BITS=4.
module tb_fp_mul_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid1 = 1'b0, in_valid2 = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] a = 32'h0, b = 32'h0;
  logic        a_zero = 1'b0, a_inf = 1'b0, a_nan = 1'b0;
  logic        b_zero = 1'b0, b_inf = 1'b0, b_nan = 1'b0;
  logic        in_ready1, out_valid1, ovf1, unf1;
  logic        in_ready2, out_valid2, ovf2, unf2;
  logic [31:0] result1, result2;

  int checks = 0;
  int failures = 0;

  localparam logic [5:0] F_NONE = 6'b000000;
  localparam logic [5:0] F_AZ   = 6'b100000;
  localparam logic [5:0] F_AI   = 6'b010000;
  localparam logic [5:0] F_AN   = 6'b001000;
  localparam logic [5:0] F_BZ   = 6'b000100;

  always #5 clk = ~clk;

  fp_mul_seq #(.RADIX_BITS(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1),
    .a(a), .b(b), .a_zero(a_zero), .a_inf(a_inf), .a_nan(a_nan),
    .b_zero(b_zero), .b_inf(b_inf), .b_nan(b_nan),
    .out_valid(out_valid1), .out_ready(out_ready), .result(result1), .ovf(ovf1), .unf(unf1)
  );

  fp_mul_seq #(.RADIX_BITS(4)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid2), .in_ready(in_ready2),
    .a(a), .b(b), .a_zero(a_zero), .a_inf(a_inf), .a_nan(a_nan),
    .b_zero(b_zero), .b_inf(b_inf), .b_nan(b_nan),
    .out_valid(out_valid2), .out_ready(out_ready), .result(result2), .ovf(ovf2), .unf(unf2)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic logic ov(input bit sel);
    return sel ? out_valid2 : out_valid1;
  endfunction

  function automatic logic ir(input bit sel);
    return sel ? in_ready2 : in_ready1;
  endfunction

  function automatic logic [31:0] res(input bit sel);
    return sel ? result2 : result1;
  endfunction

  // Issue one operation, measure latency, check result, optionally stall, then complete handshake.
  task automatic run_op(input bit sel, input string tag,
                        input logic [31:0] ta, input logic [31:0] tb, input logic [5:0] fl,
                        input logic [31:0] er, input logic eo, input logic eu,
                        input int elat, input int hold);
    int lat;
    @(negedge clk);
    a = ta;
    b = tb;
    {a_zero, a_inf, a_nan, b_zero, b_inf, b_nan} = fl;
    if (sel) in_valid2 = 1'b1;
    else     in_valid1 = 1'b1;
    chk({tag, "_in_ready"}, {31'h0, ir(sel)}, 32'h1);
    @(posedge clk);
    #1;
    in_valid1 = 1'b0;
    in_valid2 = 1'b0;
    a = 32'hDEADBEEF;
    b = 32'h12345678;
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
    end while (!ov(sel) && lat < 100);
    chk({tag, "_latency"}, lat, elat);
    chk({tag, "_result"}, res(sel), er);
    chk({tag, "_ovf"}, {31'h0, sel ? ovf2 : ovf1}, {31'h0, eo});
    chk({tag, "_unf"}, {31'h0, sel ? unf2 : unf1}, {31'h0, eu});
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      chk({tag, "_hold_valid"}, {31'h0, ov(sel)}, 32'h1);
      chk({tag, "_hold_result"}, res(sel), er);
      chk({tag, "_hold_in_ready"}, {31'h0, ir(sel)}, 32'h0);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk({tag, "_valid_drop"}, {31'h0, ov(sel)}, 32'h0);
    chk({tag, "_idle_ready"}, {31'h0, ir(sel)}, 32'h1);
  endtask

  initial begin
    logic seen;
    // Reset state
    #12;
    chk("rst_out_valid", {31'h0, out_valid1}, 32'h0);
    chk("rst_result", result1, 32'h0);
    chk("rst_flags", {30'h0, ovf1, unf1}, 32'h0);
    chk("rst_in_ready", {31'h0, in_ready1}, 32'h1);
    chk("rst_in_ready_r4", {31'h0, in_ready2}, 32'h1);
    @(negedge clk);
    rst_n = 1'b1;

    // Normal products
    run_op(0, "t1_1p5x2",   32'h3FC00000, 32'h40000000, F_NONE, 32'h40400000, 0, 0, 26, 0);
    run_op(0, "t2_m2x3",    32'hC0000000, 32'h40400000, F_NONE, 32'hC0C00000, 0, 0, 26, 0);
    run_op(0, "t2_ulp_sq",  32'h3F800001, 32'h3F800001, F_NONE, 32'h3F800002, 0, 0, 26, 0);
    run_op(0, "rne_up",     32'h3FC00001, 32'h3FC00001, F_NONE, 32'h40100002, 0, 0, 26, 0);

    // Specials
    run_op(0, "t3_infx0",   32'h7F800000, 32'h00000000, F_AI | F_BZ, 32'h7FC00000, 0, 0, 1, 0);
    run_op(0, "t3_nan",     32'h7FC00001, 32'h3F800000, F_AN, 32'h7FC00000, 0, 0, 1, 0);
    run_op(0, "neg_inf",    32'hFF800000, 32'h40000000, F_AI, 32'hFF800000, 0, 0, 1, 0);
    run_op(0, "neg_zero",   32'h80000000, 32'h3F800000, F_AZ, 32'h80000000, 0, 0, 1, 0);
    run_op(0, "subnormal",  32'h00400000, 32'h40000000, F_NONE, 32'h00000000, 0, 0, 1, 0);

    // Overflow / underflow
    run_op(0, "t4_ovf",     32'h7F000000, 32'h7F000000, F_NONE, 32'h7F800000, 1, 0, 26, 0);
    run_op(0, "t4_unf",     32'h00800000, 32'h00800000, F_NONE, 32'h00000000, 0, 1, 26, 0);

    // Output stall
    run_op(0, "t5_stall",   32'h3FC00000, 32'h40000000, F_NONE, 32'h40400000, 0, 0, 26, 10);

    // Reset during MUL
    @(negedge clk);
    a = 32'h3FC00000;
    b = 32'h40000000;
    {a_zero, a_inf, a_nan, b_zero, b_inf, b_nan} = F_NONE;
    in_valid1 = 1'b1;
    @(posedge clk);
    #1;
    in_valid1 = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #3;
    chk("t6_rst_in_ready", {31'h0, in_ready1}, 32'h1);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk);
      #1;
      seen = seen | out_valid1;
    end
    chk("t6_no_valid", {31'h0, seen}, 32'h0);
    chk("t6_in_ready", {31'h0, in_ready1}, 32'h1);
    run_op(0, "t6_after",   32'h3FC00000, 32'h40000000, F_NONE, 32'h40400000, 0, 0, 26, 0);

    // Radix-4 instance
    run_op(1, "r4_t1",      32'h3FC00000, 32'h40000000, F_NONE, 32'h40400000, 0, 0, 8, 0);
    run_op(1, "r4_t2",      32'hC0000000, 32'h40400000, F_NONE, 32'hC0C00000, 0, 0, 8, 0);
    run_op(1, "r4_ulp_sq",  32'h3F800001, 32'h3F800001, F_NONE, 32'h3F800002, 0, 0, 8, 0);
    run_op(1, "r4_rne_up",  32'h3FC00001, 32'h3FC00001, F_NONE, 32'h40100002, 0, 0, 8, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
